// File: rtl/jump_sequencer_if.sv
// jump_sequencer_if: game-FSM/renderer side signals of the jump sequencer.
interface jump_sequencer_if;
    logic [2:0]  i_state;
    logic        i_btn;
    logic        i_frame_tick;
    logic        o_jump_done;
    logic [3:0]  o_power;
    logic [31:0] o_x_man;
    logic [15:0] o_y_man;
    modport master (output i_state, i_btn, i_frame_tick,
                    input  o_jump_done, o_power, o_x_man, o_y_man);
    modport slave  (input  i_state, i_btn, i_frame_tick,
                    output o_jump_done, o_power, o_x_man, o_y_man);
endinterface

// File: rtl/jump_sequencer.sv
// jump_sequencer: charge-time measurement and frame-by-frame flight animation of one jump.
// JUMP_AUTO_RELEASE_EN: hitting MAX_POWER while charging releases the jump automatically.
module jump_sequencer #(
    parameter int MAX_POWER     = 15,
    parameter int FLIGHT_FRAMES = 16,
    parameter int X_MAX         = 639
) (
    input  logic clk_machine,
    input  logic rst_machine,
    jump_sequencer_if.slave bus
);
    localparam logic [2:0] S_INIT = 3'd0, S_RELD = 3'd1, S_ACCU = 3'd3, S_JUMP = 3'd4, S_OVER = 3'd6;
    typedef enum logic [1:0] {IDLE, CHARGE, FLIGHT, DONE} state_t;
    state_t      state_q;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  power_q, power_d;
    logic [31:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        done_q;
    logic        abort, last;
    logic [32:0] x_sum;
    always_comb begin
        abort   = bus.i_state == S_RELD || bus.i_state == S_OVER || bus.i_state == S_INIT;
        power_d = power_q == 4'(MAX_POWER) ? power_q : power_q + 4'd1;
        frame_d = frame_q + 16'd1;
        last    = frame_d == 16'(FLIGHT_FRAMES);
        x_sum   = {1'b0, x_q} + 33'(power_q);
        x_d     = x_sum > 33'(X_MAX) ? 32'(X_MAX) : x_sum[31:0];
        y_d     = last ? 16'd0 : frame_d * (16'(FLIGHT_FRAMES) - frame_d);
    end
    always_ff @(posedge clk_machine or posedge rst_machine)
        if (rst_machine) begin
            state_q <= IDLE;
            frame_q <= '0;
            power_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (bus.i_state == S_RELD) begin
                        x_q     <= '0;
                        y_q     <= '0;
                        power_q <= '0;
                    end else if (bus.i_state == S_ACCU) begin
                        state_q <= CHARGE;
                        power_q <= '0;
                    end
                CHARGE:
                    if (abort) begin
                        state_q <= IDLE;
                        y_q     <= '0;
                    end else if (!bus.i_btn) begin
                        done_q  <= 1'b1;
                        power_q <= power_q == 4'd0 ? 4'd1 : power_q;
                        frame_q <= '0;
                        state_q <= FLIGHT;
                    end else if (bus.i_frame_tick) begin
                        power_q <= power_d;
`ifdef JUMP_AUTO_RELEASE_EN
                        if (power_d == 4'(MAX_POWER)) begin
                            done_q  <= 1'b1;
                            frame_q <= '0;
                            state_q <= FLIGHT;
                        end
`endif
                    end
                FLIGHT:
                    if (abort) begin
                        state_q <= IDLE;
                        y_q     <= '0;
                    end else if (bus.i_state == S_JUMP && bus.i_frame_tick) begin
                        frame_q <= frame_d;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                DONE:
                    if (bus.i_state != S_JUMP) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    assign bus.o_jump_done = done_q;
    assign bus.o_power     = power_q;
    assign bus.o_x_man     = x_q;
    assign bus.o_y_man     = y_q;
endmodule

// File: tb/tb_jump_sequencer.sv
// tb_jump_sequencer: randomized jumps checked against an arithmetic model of charge and flight.
module tb_jump_sequencer;
    localparam int MAXP = 15, FF = 16, XMAX = 639;
    localparam logic [2:0] INIT = 3'd0, RELD = 3'd1, WAIT = 3'd2, ACCU = 3'd3, JUMP = 3'd4, LAND = 3'd5, OVER = 3'd6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_fail = 0;
    int   pulses = 0, gap = 2;
    int   exp_x = 0;
    logic prev_done = 1'b0;
    jump_sequencer_if bus();
    jump_sequencer dut (.clk_machine(clk), .rst_machine(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic step(input logic [2:0] st, input logic btn, input logic tick);
        bus.i_state = st;
        bus.i_btn = btn;
        bus.i_frame_tick = tick;
        @(posedge clk);
        #1;
        chk("no_double_pulse", int'(prev_done && bus.o_jump_done), 0);
        if (bus.o_jump_done) pulses++;
        prev_done = bus.o_jump_done;
    endtask
    task automatic idle_gap(input logic [2:0] st, input logic btn);
        repeat ($urandom_range(0, gap)) step(st, btn, 1'b0);
    endtask
    // mode 0: full flight, 1: abort by RELD after nf ticks, 2: reset after nf ticks
    task automatic jump(input int n, input bit coincide, input int nf, input int mode);
        int p, x0, auto_rel;
        x0 = exp_x;
        auto_rel = 0;
        step(WAIT, 1'b0, 1'b0);
        step(ACCU, 1'b1, 1'b0);
        chk("charge_start_power", bus.o_power, 0);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            idle_gap(ACCU, 1'b1);
            step(ACCU, 1'b1, 1'b1);
            p = (i + 1 > MAXP) ? MAXP : i + 1;
            chk("charge_power", bus.o_power, p);
`ifdef JUMP_AUTO_RELEASE_EN
            chk("auto_release_pulse", bus.o_jump_done, int'(i + 1 == MAXP));
            if (i + 1 == MAXP) auto_rel = 1;
`else
            chk("no_pulse_while_held", pulses, 0);
`endif
        end
        step(ACCU, 1'b0, coincide);
        p = n > MAXP ? MAXP : (n == 0 ? 1 : n);
        chk("release_pulse", bus.o_jump_done, auto_rel ? 0 : 1);
        chk("charge_pulse_count", pulses, 1);
        chk("latched_power", bus.o_power, p);
        step(ACCU, 1'b0, 1'b1);
        chk("no_motion_in_accu", bus.o_x_man, x0);
        for (int f = 1; f <= nf; f++) begin
            idle_gap(JUMP, 1'b0);
            step(JUMP, 1'b0, 1'b1);
            exp_x = (x0 + p * f > XMAX) ? XMAX : x0 + p * f;
            chk("flight_x", bus.o_x_man, exp_x);
            chk("flight_y", bus.o_y_man, f == FF ? 0 : f * (FF - f));
            chk("flight_pulse", bus.o_jump_done, int'(f == FF));
        end
        if (mode == 0) begin
            step(LAND, 1'b0, 1'b0);
            chk("land_x_hold", bus.o_x_man, exp_x);
            chk("land_power_hold", bus.o_power, p);
            chk("jump_pulse_count", pulses, 2);
        end else if (mode == 1) begin
            step(RELD, 1'b0, 1'b1);
            chk("abort_x_hold", bus.o_x_man, exp_x);
            chk("abort_y_zero", bus.o_y_man, 0);
            chk("abort_no_pulse", pulses, 1);
            step(RELD, 1'b0, 1'b0);
            exp_x = 0;
            chk("rebase_x", bus.o_x_man, 0);
        end else begin
            chk("pre_reset_x", bus.o_x_man, exp_x);
            rst = 1'b1;
            #1;
            chk("async_rst_x", bus.o_x_man, 0);
            chk("async_rst_y", bus.o_y_man, 0);
            chk("async_rst_power", bus.o_power, 0);
            chk("async_rst_done", bus.o_jump_done, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            prev_done = 1'b0;
            exp_x = 0;
        end
    endtask
    task automatic rebase();
        step(RELD, 1'b0, 1'b0);
        exp_x = 0;
        chk("rebase_x", bus.o_x_man, 0);
        chk("rebase_power", bus.o_power, 0);
    endtask
    initial begin
        int ft;
        bus.i_state = INIT;
        bus.i_btn = 1'b0;
        bus.i_frame_tick = 1'b0;
        #1;
        chk("reset_x", bus.o_x_man, 0);
        chk("reset_y", bus.o_y_man, 0);
        chk("reset_power", bus.o_power, 0);
        chk("reset_done", bus.o_jump_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rebase();
        jump(5, 1'b0, FF, 0);
        chk("five_tick_x", exp_x, 80);
        rebase();
        jump(0, 1'b0, FF, 0);
        chk("min_hop_x", bus.o_x_man, 16);
        rebase();
        jump(20, 1'b0, FF, 0);
        chk("full_power_x", bus.o_x_man, 240);
        rebase();
        jump(3, 1'b1, FF, 0);
        chk("coincide_power", bus.o_power, 3);
        rebase();
        repeat (3) jump(15, 1'b0, FF, 0);
        chk("x_saturated", bus.o_x_man, XMAX);
        rebase();
        step(ACCU, 1'b1, 1'b0);
        step(OVER, 1'b1, 1'b1);
        chk("charge_abort_y", bus.o_y_man, 0);
        chk("charge_abort_no_pulse", bus.o_jump_done, 0);
        rebase();
        jump(7, 1'b0, 5, 1);
        rebase();
        jump(5, 1'b0, 8, 2);
        for (int k = 0; k < 10; k++) begin
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) rebase();
            ft = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FF - 1) : FF;
            jump($urandom_range(0, 20), 1'($urandom_range(0, 1)), ft, ft == FF ? 0 : 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
